// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Two-requester round-robin controller for a shared 4-chip async
//            SRAM bus; one access per command with an idle turnaround cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 8,
    parameter int CS_WIDTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_write,
    input  logic [2*(CS_WIDTH+ADDR_WIDTH)-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]              req_wdata,
    output logic [1:0]                           rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [ADDR_WIDTH-1:0]                bus_address,
    output logic [CS_WIDTH-1:0]                  bus_chip_select,
    output logic                                 bus_read_enable,
    output logic                                 bus_write_enable,
    output logic [DATA_WIDTH-1:0]                bus_wdata,
    output logic                                 bus_data_oe,
    input  logic [DATA_WIDTH-1:0]                bus_rdata
);

    localparam int REQ_AW = CS_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_winner;
    logic                  r_op_write;

    logic                  w_winner;
    logic [1:0]            w_ready;
    logic                  w_accept;
    logic                  w_sel_write;
    logic [REQ_AW-1:0]     w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        w_winner = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_ready  = 2'b00;
        if (r_state == ST_IDLE && req_valid[w_winner]) begin
            w_ready[w_winner] = 1'b1;
        end
        w_accept    = |w_ready;
        w_sel_write = req_write[w_winner];
        w_sel_addr  = w_winner ? req_addr[REQ_AW +: REQ_AW] : req_addr[0 +: REQ_AW];
        w_sel_wdata = w_winner ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                               : req_wdata[0 +: DATA_WIDTH];
    end

    assign req_ready = w_ready;

    // The bus output registers double as the latched command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= 1'b1;
            r_winner         <= 1'b0;
            r_op_write       <= 1'b0;
            rsp_valid        <= 2'b00;
            rsp_data         <= '0;
            bus_address      <= '0;
            bus_chip_select  <= '0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_wdata        <= '0;
            bus_data_oe      <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_winner                        <= w_winner;
                        r_last_grant                    <= w_winner;
                        r_op_write                      <= w_sel_write;
                        {bus_chip_select, bus_address}  <= w_sel_addr;
                        bus_wdata                       <= w_sel_wdata;
                        bus_read_enable                 <= ~w_sel_write;
                        bus_write_enable                <= w_sel_write;
                        bus_data_oe                     <= w_sel_write;
                        r_state                         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_op_write) begin
                        rsp_data <= bus_rdata;
                    end
                    bus_read_enable     <= 1'b0;
                    bus_write_enable    <= 1'b0;
                    bus_data_oe         <= 1'b0;
                    rsp_valid[r_winner] <= 1'b1;
                    r_state             <= ST_TURN;
                end
                ST_TURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_arbiter
// Purpose  : Self-checking bench: SRAM bus model plus transaction-level
//            reference of arbitration, access timing and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 8;
    localparam int CW  = 2;
    localparam int RAW = CW + AW;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_write = 2'b00;
    logic [2*RAW-1:0] req_addr  = '0;
    logic [2*DW-1:0]  req_wdata = '0;
    logic [DW-1:0]    bus_rdata = '0;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [AW-1:0]    bus_address;
    logic [CW-1:0]    bus_chip_select;
    logic             bus_read_enable;
    logic             bus_write_enable;
    logic [DW-1:0]    bus_wdata;
    logic             bus_data_oe;

    sram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CS_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .bus_address      (bus_address),
        .bus_chip_select  (bus_chip_select),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_wdata        (bus_wdata),
        .bus_data_oe      (bus_data_oe),
        .bus_rdata        (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sram    [logic [RAW-1:0]];
    logic [DW-1:0] ref_mem [logic [RAW-1:0]];

    // Reference: phase counts cycles since acceptance (0 = free to accept).
    int             ph       = 0;
    logic           last_win = 1'b1;
    logic           cur_who  = 1'b0;
    logic           cur_wr   = 1'b0;
    logic [RAW-1:0] cur_addr = '0;
    logic [DW-1:0]  cur_wdata = '0;
    logic [1:0]     acc_mask = 2'b00;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] sram_rd(input logic [RAW-1:0] a);
        return sram.exists(a) ? sram[a] : '0;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [RAW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [RAW-1:0] rnd_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 3))
            0:       a = 22'h000000;
            1:       a = 22'h001234;
            2:       a = 22'h3FFFFF;
            default: a = 22'h2AAAAA;
        endcase
        return {2'($urandom_range(0, 3)), a};
    endfunction

    task automatic issue(input int r, input logic w, input logic [RAW-1:0] a, input logic [DW-1:0] d);
        req_write[r]          = w;
        req_addr[r*RAW +: RAW] = a;
        req_wdata[r*DW +: DW]  = d;
        req_valid[r]          = 1'b1;
    endtask

    // One clock: bus model and checks at negedge, input update after posedge.
    task automatic tick();
        logic [1:0] exp_rdy;
        @(negedge clk);
        acc_mask  = 2'b00;
        bus_rdata = '0;
        if (bus_read_enable)  bus_rdata = sram_rd({bus_chip_select, bus_address});
        if (bus_write_enable) sram[{bus_chip_select, bus_address}] = bus_wdata;
        chk_val("rw_exclusive", {31'd0, bus_read_enable & bus_write_enable}, 0);
        case (ph)
            0: begin
                if (req_valid == 2'b11) exp_rdy = last_win ? 2'b01 : 2'b10;
                else                    exp_rdy = req_valid;
                chk_val("ready", {30'd0, req_ready}, {30'd0, exp_rdy});
                chk_val("idle_strobes", {29'd0, bus_read_enable, bus_write_enable, bus_data_oe}, 0);
                chk_val("idle_rsp", {30'd0, rsp_valid}, 0);
                if (exp_rdy != 2'b00) begin
                    cur_who   = exp_rdy[1];
                    cur_wr    = req_write[cur_who];
                    cur_addr  = cur_who ? req_addr[RAW +: RAW] : req_addr[0 +: RAW];
                    cur_wdata = cur_who ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
                    last_win  = cur_who;
                    acc_mask  = exp_rdy;
                    ph        = 1;
                end
            end
            1: begin
                chk_val("acc_ready", {30'd0, req_ready}, 0);
                chk_val("acc_addr", {8'd0, bus_chip_select, bus_address}, {8'd0, cur_addr});
                chk_val("acc_strobes", {29'd0, bus_read_enable, bus_write_enable, bus_data_oe},
                        cur_wr ? 32'd3 : 32'd4);
                if (cur_wr) chk_val("acc_wdata", {24'd0, bus_wdata}, {24'd0, cur_wdata});
                chk_val("acc_rsp", {30'd0, rsp_valid}, 0);
                ph = 2;
            end
            default: begin
                chk_val("turn_ready", {30'd0, req_ready}, 0);
                chk_val("turn_strobes", {29'd0, bus_read_enable, bus_write_enable, bus_data_oe}, 0);
                chk_val("turn_addr_hold", {8'd0, bus_chip_select, bus_address}, {8'd0, cur_addr});
                chk_val("turn_rsp", {30'd0, rsp_valid}, cur_who ? 32'd2 : 32'd1);
                if (!cur_wr) chk_val("rsp_data", {24'd0, rsp_data}, {24'd0, ref_rd(cur_addr)});
                else         ref_mem[cur_addr] = cur_wdata;
                ph = 0;
            end
        endcase
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != 2'b00 || ph != 0) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk_val("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int cyc;
        int prev;
        #12;
        chk_val("reset_outputs", {rsp_valid, req_ready, bus_read_enable, bus_write_enable,
                bus_data_oe, 3'd0, rsp_data, bus_wdata}, 0);
        chk_val("reset_bus_addr", {8'd0, bus_chip_select, bus_address}, 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single write then read-back of the same location.
        issue(0, 1'b1, {2'd2, 22'h001234}, 8'hA5);
        drain();
        issue(0, 1'b0, {2'd2, 22'h001234}, 8'h00);
        drain();

        // Continuous contention: alternation and 3-cycle accept spacing.
        cyc  = 0;
        prev = -1;
        for (int c = 0; c < 14; c++) begin
            for (int r = 0; r < 2; r++)
                if (!req_valid[r]) issue(r, 1'b0, {2'(r), 22'h001234}, 8'h00);
            tick();
            cyc++;
            if (acc_mask != 2'b00) begin
                if (prev >= 0) chk_val("accept_spacing", cyc - prev, 3);
                prev = cyc;
            end
        end
        req_valid = 2'b00;
        drain();

        // Write followed directly by a read from the other requester.
        issue(0, 1'b1, {2'd1, 22'h000ABC}, 8'h3C);
        issue(1, 1'b0, {2'd1, 22'h000ABC}, 8'h00);
        drain();

        // Chip-select sweep at the top address, then read-back.
        for (int cs = 0; cs < 4; cs++) begin
            issue(cs % 2, 1'b1, {2'(cs), 22'h3FFFFF}, 8'(8'h10 + cs));
            drain();
        end
        for (int cs = 0; cs < 4; cs++) begin
            issue(1 - cs % 2, 1'b0, {2'(cs), 22'h3FFFFF}, 8'h00);
            drain();
        end

        // Held request: req1 first, req0 arrives a cycle later and waits.
        issue(1, 1'b0, {2'd0, 22'h000000}, 8'h00);
        tick();
        issue(0, 1'b1, {2'd3, 22'h000000}, 8'h5A);
        tick();
        req_wdata[0 +: DW] = 8'h66;
        drain();

        // Randomized traffic with held and mutating requests.
        for (int c = 0; c < 500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0)
                    issue(r, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)));
                else if (req_valid[r] && $urandom_range(0, 7) == 0)
                    req_wdata[r*DW +: DW] = 8'($urandom_range(0, 255));
            end
            tick();
        end
        drain();

        // Reset during the ACCESS cycle of a write.
        issue(0, 1'b1, {2'd1, 22'h000055}, 8'h77);
        for (int k = 0; k < 10 && ph != 1; k++) tick();
        chk_val("pre_reset_we", {31'd0, bus_write_enable}, 1);
        #2 reset = 1'b1;
        #1;
        chk_val("async_reset_strobes", {29'd0, bus_read_enable, bus_write_enable, bus_data_oe}, 0);
        @(posedge clk);
        #1;
        chk_val("reset_no_rsp", {30'd0, rsp_valid}, 0);
        ph       = 0;
        last_win = 1'b1;
        issue(1, 1'b0, {2'd0, 22'h000100}, 8'h00);
        issue(0, 1'b0, {2'd0, 22'h000101}, 8'h00);
        #2 reset = 1'b0;
        tick();
        chk_val("post_reset_grant0", {31'd0, acc_mask[0]}, 1);
        drain();
        chk_val("reset_write_dropped", {31'd0, sram.exists({2'd1, 22'h000055}) ? 1'b1 : 1'b0}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
